// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// Fixed latency of WIDTH+1 cycles from start to the single-cycle data_resultRDY pulse.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] ctrl_tag_in,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    counter;
    logic             op_div;
    logic [TAG_W-1:0] tag_reg;
    logic             start;
    logic             last_iter;

    // Booth state: upper half carries two guard bits so that adding or
    // subtracting the most negative multiplicand can never wrap.
    logic [WIDTH+1:0] hi, hi_sum, hi_next, mcand;
    logic [WIDTH-1:0] lo, lo_next;
    logic             q_prev;
    logic [WIDTH:0]   prod_mid;
    logic             mul_ovf;

    // Divider state: signed partial remainder, quotient shift register, divisor magnitude.
    logic [WIDTH+1:0] rem, rem_shift, rem_next, dvs_ext;
    logic [WIDTH-1:0] quo, quo_next, quo_fixed, dvs;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             neg, div_zero, div_ovf;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_iter = (counter == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hi_sum = hi;
        case ({lo[0], q_prev})
            2'b01:   hi_sum = hi + mcand;
            2'b10:   hi_sum = hi - mcand;
            default: hi_sum = hi;
        endcase
        hi_next  = {hi_sum[WIDTH+1], hi_sum[WIDTH+1:1]};
        lo_next  = {hi_sum[0], lo[WIDTH-1:1]};
        prod_mid = {hi[WIDTH-1:0], lo[WIDTH-1]};
        mul_ovf  = !((&prod_mid) || !(|prod_mid));
    end

    // Non-restoring step: the sign of the new remainder is the next quotient bit.
    always_comb begin
        dvs_ext   = {2'b00, dvs};
        rem_shift = {rem[WIDTH:0], quo[WIDTH-1]};
        rem_next  = rem[WIDTH+1] ? (rem_shift + dvs_ext) : (rem_shift - dvs_ext);
        quo_next  = {quo[WIDTH-2:0], ~rem_next[WIDTH+1]};
        quo_fixed = neg ? -quo : quo;
        abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            op_div         <= 1'b0;
            tag_reg        <= '0;
            hi             <= '0;
            lo             <= '0;
            q_prev         <= 1'b0;
            mcand          <= '0;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            tag_out        <= '0;
        end else begin
            state          <= state_next;
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div   <= ~ctrl_MULT;
                        tag_reg  <= ctrl_tag_in;
                        counter  <= '0;
                        hi       <= '0;
                        lo       <= data_operandB;
                        q_prev   <= 1'b0;
                        mcand    <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                        rem      <= '0;
                        quo      <= abs_a;
                        dvs      <= abs_b;
                        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_zero <= (data_operandB == '0);
                        div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (op_div) begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end else begin
                        hi     <= hi_next;
                        lo     <= lo_next;
                        q_prev <= lo[0];
                    end
                end
                DONE: begin
                    data_resultRDY <= 1'b1;
                    tag_out        <= tag_reg;
                    if (!op_div) begin
                        data_result    <= lo;
                        data_exception <= mul_ovf;
                    end else if (div_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= quo_fixed;
                        data_exception <= div_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed testbench for multdiv_unit: table of hand-computed vectors plus
// hand-written contention, back-to-back and mid-operation reset sequences.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_tag_in;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [4:0]  tag_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mul;
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[15];

    multdiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_tag_in    (ctrl_tag_in),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .tag_out        (tag_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic mul, input logic div, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag);
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        ctrl_tag_in   = tag;
    endtask

    task automatic clear_start();
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom();
        data_operandB = $urandom();
        ctrl_tag_in   = 5'($urandom());
    endtask

    task automatic apply_stimulus(input logic mul, input logic div, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] tag);
        @(negedge clock);
        drive_start(mul, div, a, b, tag);
        @(negedge clock);
        clear_start();
    endtask

    // Called at the first negedge after the start edge; returns at the negedge where RDY is seen.
    // A non-zero pulse_at raises ctrl_DIV for one cycle at that negedge index.
    task automatic wait_result(input int pulse_at, output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!data_resultRDY && lat < 100) begin
            @(negedge clock);
            lat++;
            ctrl_DIV = (lat == pulse_at);
            if (busy) busy_cnt++;
        end
        ctrl_DIV = 1'b0;
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int pulses;
        int busy_seen;
        pulses    = 0;
        busy_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
            if (busy) busy_seen++;
        end
        check_output({name, " extra rdy"}, 32'(pulses), 32'd0);
        check_output({name, " extra busy"}, 32'(busy_seen), 32'd0);
    endtask

    initial begin
        int lat;
        int bcnt;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 5'd5,  32'hFFFFFFD6, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 5'd1,  32'h00000000, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd1,        5'd2,  32'h7FFFFFFF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 5'd3,  32'h00000000, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        5'd4,  32'h80000000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000001, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'd6,        32'd7,        5'd7,  32'h0000002A, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        5'd8,  32'hFFFFFFF2, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 5'd9,  32'hFFFFFFF2, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'd0,        32'd5,        5'd10, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'd1234,     32'd0,        5'd11, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h80000000, 32'd2,        5'd13, 32'hC0000000, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h80000000, 5'd14, 32'h00000000, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFF9, 5'd15, 32'hFFFFFFFF, 1'b0};

        reset = 1'b1;
        clear_start();
        repeat (3) @(negedge clock);
        check_output("reset result", data_result, 32'd0);
        check_output("reset exc", 32'(data_exception), 32'd0);
        check_output("reset rdy", 32'(data_resultRDY), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset tag", 32'(tag_out), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].mul, vecs[i].div, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_result(0, lat, bcnt);
            check_output($sformatf("v%0d latency", i), 32'(lat), 32'd34);
            check_output($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'd33);
            check_output($sformatf("v%0d result", i), data_result, vecs[i].res);
            check_output($sformatf("v%0d exc", i), 32'(data_exception), 32'(vecs[i].exc));
            check_output($sformatf("v%0d tag", i), 32'(tag_out), 32'(vecs[i].tag));
            @(negedge clock);
            check_output($sformatf("v%0d rdy drop", i), 32'(data_resultRDY), 32'd0);
            check_output($sformatf("v%0d result hold", i), data_result, vecs[i].res);
        end

        // Divide strobe mid-multiply, then one in the DONE cycle: both must be ignored.
        apply_stimulus(1'b1, 1'b0, 32'd3, 32'd5, 5'd2);
        wait_result(10, lat, bcnt);
        check_output("contend10 latency", 32'(lat), 32'd34);
        check_output("contend10 result", data_result, 32'd15);
        check_output("contend10 tag", 32'(tag_out), 32'd2);
        check_quiet("contend10", 40);

        apply_stimulus(1'b1, 1'b0, 32'd9, 32'd9, 5'd3);
        wait_result(33, lat, bcnt);
        check_output("contend33 latency", 32'(lat), 32'd34);
        check_output("contend33 result", data_result, 32'd81);
        check_quiet("contend33", 40);

        // Start accepted in the RDY cycle.
        apply_stimulus(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, 5'd5);
        wait_result(0, lat, bcnt);
        check_output("b2b first result", data_result, 32'hFFFFFFD6);
        drive_start(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 5'd9);
        @(negedge clock);
        clear_start();
        check_output("b2b busy", 32'(busy), 32'd1);
        wait_result(0, lat, bcnt);
        check_output("b2b second latency", 32'(lat), 32'd34);
        check_output("b2b second result", data_result, 32'hFFFFFFF2);
        check_output("b2b second tag", 32'(tag_out), 32'd9);

        // Reset in the middle of a divide.
        apply_stimulus(1'b0, 1'b1, 32'd1000, 32'd3, 5'd7);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_output("abort result", data_result, 32'd0);
        check_output("abort exc", 32'(data_exception), 32'd0);
        check_output("abort rdy", 32'(data_resultRDY), 32'd0);
        check_output("abort busy", 32'(busy), 32'd0);
        check_output("abort tag", 32'(tag_out), 32'd0);
        check_quiet("abort", 40);

        apply_stimulus(1'b1, 1'b0, 32'd3, 32'd4, 5'd4);
        wait_result(0, lat, bcnt);
        check_output("post reset latency", 32'(lat), 32'd34);
        check_output("post reset result", data_result, 32'd12);
        check_output("post reset tag", 32'(tag_out), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
